// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the sequential shift unit.
//   shift_op_e : shift mode encodings (LSL, LSR, ASR, ROR)
//   state_e    : control states of the shift unit FSM
//   F_N..F_V   : bit positions of the NZCV flags inside the 4-bit flag bus
// ---------------------------------------------------------------------------
package shift_pkg;

    typedef enum logic [1:0] {
        OP_LSL = 2'd0,
        OP_LSR = 2'd1,
        OP_ASR = 2'd2,
        OP_ROR = 2'd3
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int F_N = 3;
    localparam int F_Z = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;

endpackage

// File: rtl/shift_step.sv
// ---------------------------------------------------------------------------
// shift_step
// Combinational single-iteration shifter used once per SHIFT cycle.
//   value   : in  WIDTH  current working value
//   op      : in  2      shift mode
//   s       : in  S_W    positions to shift this iteration, 0..STEP
//   shifted : out WIDTH  value after shifting by s
//   carry   : out 1      last bit shifted out during this iteration (0 if s=0)
// ---------------------------------------------------------------------------
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int S_W   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] value,
    input  shift_op_e        op,
    input  logic [S_W-1:0]   s,
    output logic [WIDTH-1:0] shifted,
    output logic             carry
);

    // One extra guard bit beside the operand catches the last bit pushed out,
    // so the carry falls out of the same shift that produces the result.
    logic        [WIDTH:0] wide;
    logic signed [WIDTH:0] wide_s;

    always_comb begin
        wide    = '0;
        wide_s  = '0;
        shifted = value;
        carry   = 1'b0;
        case (op)
            OP_LSL: begin
                wide    = {1'b0, value} << s;
                shifted = wide[WIDTH-1:0];
                carry   = wide[WIDTH];
            end
            OP_LSR: begin
                wide    = {value, 1'b0} >> s;
                shifted = wide[WIDTH:1];
                carry   = wide[0];
            end
            OP_ASR: begin
                wide_s  = $signed({value, 1'b0}) >>> s;
                shifted = wide_s[WIDTH:1];
                carry   = wide_s[0];
            end
            OP_ROR: begin
                // For s=0 the left-shift term vanishes and value passes through.
                shifted = (value >> s) | (value << (WIDTH - int'(s)));
                carry   = (s != '0) && shifted[WIDTH-1];
            end
            default: begin
                shifted = value;
                carry   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// ---------------------------------------------------------------------------
// shift_unit_seq
// Multi-cycle shifter (LSL/LSR/ASR/ROR) shifting up to STEP positions per
// clock, with a start/busy/done handshake and packed NZCV flags.
//   clk    : in  1        system clock, rising edge
//   rst    : in  1        synchronous active-high reset
//   start  : in  1        request, accepted when not busy
//   op     : in  2        mode 0=LSL 1=LSR 2=ASR 3=ROR, sampled on accept
//   din    : in  WIDTH    operand, sampled on accept
//   amount : in  AMT_W    unsigned shift count, sampled on accept
//   busy   : out 1        high while shifting
//   done   : out 1        one-cycle pulse when result/flags become valid
//   result : out WIDTH    shifted value, held until the next completion
//   flags  : out 4        {N,Z,C,V}, held with result
//   out    : out WIDTH+4  {flags,result}
// ---------------------------------------------------------------------------
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 8,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic [WIDTH+3:0] out
);

    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam int S_W   = $clog2(STEP + 1);

    state_e           state;
    shift_op_e        op_q;
    logic             sign_q;
    logic [WIDTH-1:0] work;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] n_eff;
    logic [31:0]      amt_ext;
    logic [S_W-1:0]   step_s;
    logic [WIDTH-1:0] step_out;
    logic             step_c;
    logic             last_step;

    // Clamp the requested count: logical shifts saturate one past WIDTH so the
    // final carry is a shifted-in zero, ASR saturates at WIDTH (all sign bits),
    // and rotates wrap modulo WIDTH.
    always_comb begin
        amt_ext = 32'(amount);
        n_eff   = '0;
        case (shift_op_e'(op))
            OP_LSL, OP_LSR: n_eff = CNT_W'((amt_ext > 32'(WIDTH + 1)) ? 32'(WIDTH + 1) : amt_ext);
            OP_ASR:         n_eff = CNT_W'((amt_ext > 32'(WIDTH)) ? 32'(WIDTH) : amt_ext);
            OP_ROR:         n_eff = CNT_W'(amt_ext % 32'(WIDTH));
            default:        n_eff = '0;
        endcase
    end

    always_comb begin
        step_s    = (remaining > CNT_W'(STEP)) ? S_W'(STEP) : S_W'(remaining);
        last_step = (remaining <= CNT_W'(STEP));
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .S_W   (S_W)
    ) u_step (
        .value   (work),
        .op      (op_q),
        .s       (step_s),
        .shifted (step_out),
        .carry   (step_c)
    );

    // Control FSM. A zero effective count skips SHIFT entirely; a rotate by a
    // nonzero multiple of WIDTH still reports the MSB as carry, since the last
    // bit rotated out lands there.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            flags     <= '0;
            work      <= '0;
            remaining <= '0;
            op_q      <= OP_LSL;
            sign_q    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        op_q   <= shift_op_e'(op);
                        sign_q <= din[WIDTH-1];
                        if (n_eff == '0) begin
                            result     <= din;
                            flags[F_N] <= din[WIDTH-1];
                            flags[F_Z] <= (din == '0);
                            flags[F_C] <= (op == OP_ROR) && (amount != '0) && din[WIDTH-1];
                            flags[F_V] <= 1'b0;
                            done       <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            work      <= din;
                            remaining <= n_eff;
                            busy      <= 1'b1;
                            state     <= ST_SHIFT;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    work      <= step_out;
                    remaining <= remaining - CNT_W'(step_s);
                    if (last_step) begin
                        result     <= step_out;
                        flags[F_N] <= step_out[WIDTH-1];
                        flags[F_Z] <= (step_out == '0);
                        flags[F_C] <= step_c;
                        flags[F_V] <= (op_q == OP_LSL) && (step_out[WIDTH-1] != sign_q);
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out = {flags, result};

endmodule

// File: tb/tb_shift_unit_seq.sv
// ---------------------------------------------------------------------------
// tb_shift_unit_seq
// Self-checking bench for shift_unit_seq (WIDTH=32, AMT_W=8, STEP=4).
// Expected values come from an arithmetic reference model of the shift rules.
// ---------------------------------------------------------------------------
module tb_shift_unit_seq;

    localparam int WIDTH = 32;
    localparam int AMT_W = 8;
    localparam int STEP  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] din;
    logic [AMT_W-1:0] amount;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic [WIDTH+3:0] out;

    int               tests_run    = 0;
    int               tests_failed = 0;
    logic [WIDTH-1:0] prev_result  = '0;

    shift_unit_seq #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W),
        .STEP  (STEP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .din    (din),
        .amount (amount),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flags  (flags),
        .out    (out)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model: shift rules applied directly with whole-word arithmetic,
    // plus the number of SHIFT cycles expected before done.
    function automatic void model(input logic [1:0] m, input logic [WIDTH-1:0] d,
                                  input logic [AMT_W-1:0] a,
                                  output logic [WIDTH-1:0] r, output logic [3:0] f,
                                  output int edges);
        int   n;
        int   ai;
        logic c;
        ai = int'(a);
        case (m)
            2'd0, 2'd1: n = (ai > WIDTH + 1) ? WIDTH + 1 : ai;
            2'd2:       n = (ai > WIDTH) ? WIDTH : ai;
            default:    n = ai % WIDTH;
        endcase
        r = d;
        c = 1'b0;
        if (n > 0) begin
            case (m)
                2'd0: begin
                    r = (n >= WIDTH) ? '0 : d << n;
                    c = (n <= WIDTH) ? d[WIDTH - n] : 1'b0;
                end
                2'd1: begin
                    r = (n >= WIDTH) ? '0 : d >> n;
                    c = (n <= WIDTH) ? d[n - 1] : 1'b0;
                end
                2'd2: begin
                    r = (n >= WIDTH) ? {WIDTH{d[WIDTH-1]}} : WIDTH'($signed(d) >>> n);
                    c = d[n - 1];
                end
                default: begin
                    r = (d >> n) | (d << (WIDTH - n));
                    c = r[WIDTH-1];
                end
            endcase
        end else if (m == 2'd3 && a != '0) begin
            c = d[WIDTH-1];
        end
        f = {r[WIDTH-1], (r == '0), c, (m == 2'd0) && (r[WIDTH-1] != d[WIDTH-1])};
        edges = (n + STEP - 1) / STEP;
    endfunction

    // Issue one request, follow it to done, and check latency, busy, hold and
    // the final result/flags. pulse_at >= 0 fires an extra start mid-shift.
    task automatic applyStimulus(input logic [1:0] m, input logic [WIDTH-1:0] d,
                                 input logic [AMT_W-1:0] a, input string tag,
                                 input int pulse_at);
        logic [WIDTH-1:0] exp_r;
        logic [3:0]       exp_f;
        int               exp_edges;
        int               edges;
        model(m, d, a, exp_r, exp_f, exp_edges);
        op     = m;
        din    = d;
        amount = a;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 0;
        while (done !== 1'b1 && edges < 20) begin
            checkOutput({tag, " busy"}, 64'(busy), 64'(1'b1));
            checkOutput({tag, " hold"}, 64'(result), 64'(prev_result));
            if (edges == pulse_at) begin
                start  = 1'b1;
                op     = 2'd0;
                din    = ~d;
                amount = 8'd1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            edges++;
        end
        checkOutput({tag, " latency"}, 64'(edges), 64'(exp_edges));
        checkOutput({tag, " done"},    64'(done),  64'(1'b1));
        checkOutput({tag, " busy_end"}, 64'(busy), 64'(1'b0));
        checkOutput({tag, " result"},  64'(result), 64'(exp_r));
        checkOutput({tag, " flags"},   64'(flags),  64'(exp_f));
        checkOutput({tag, " out"},     64'(out),    64'({exp_f, exp_r}));
        prev_result = exp_r;
    endtask

    // One cycle with no request: done must have dropped and outputs held.
    task automatic idleCycle(input string tag);
        @(posedge clk);
        #1;
        checkOutput({tag, " done_low"}, 64'(done),   64'(1'b0));
        checkOutput({tag, " idle_busy"}, 64'(busy),  64'(1'b0));
        checkOutput({tag, " idle_hold"}, 64'(result), 64'(prev_result));
    endtask

    initial begin
        logic [1:0]       m;
        logic [WIDTH-1:0] d;
        logic [AMT_W-1:0] a;

        rst    = 1'b1;
        start  = 1'b0;
        op     = 2'd0;
        din    = '0;
        amount = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy",   64'(busy),   64'(0));
        checkOutput("reset done",   64'(done),   64'(0));
        checkOutput("reset result", 64'(result), 64'(0));
        checkOutput("reset flags",  64'(flags),  64'(0));
        checkOutput("reset out",    64'(out),    64'(0));
        rst = 1'b0;
        idleCycle("post_reset");

        applyStimulus(2'd1, 32'h000000F0, 8'd4,  "lsr4", -1);
        idleCycle("lsr4");
        applyStimulus(2'd2, 32'h80000000, 8'd40, "asr40", -1);
        applyStimulus(2'd0, 32'h40000001, 8'd1,  "lsl1", -1);
        applyStimulus(2'd3, 32'h00000001, 8'd33, "ror33", -1);
        applyStimulus(2'd3, 32'h00000001, 8'd32, "ror32", -1);
        idleCycle("ror32");
        applyStimulus(2'd1, 32'hFFFFFFFF, 8'd33, "lsr33", 2);
        idleCycle("lsr33_a");
        idleCycle("lsr33_b");
        applyStimulus(2'd0, 32'h80000001, 8'd32, "lsl32", -1);
        applyStimulus(2'd3, 32'hA5A5A5A5, 8'd0,  "ror0", -1);

        // Reset during the third SHIFT cycle aborts without a done pulse.
        op     = 2'd1;
        din    = 32'hDEADBEEF;
        amount = 8'd20;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort busy",   64'(busy),   64'(0));
        checkOutput("abort done",   64'(done),   64'(0));
        checkOutput("abort result", 64'(result), 64'(0));
        checkOutput("abort flags",  64'(flags),  64'(0));
        prev_result = '0;
        repeat (6) idleCycle("abort");
        applyStimulus(2'd1, 32'h00000000, 8'd0, "lsr0_zero", -1);

        for (int i = 0; i < 60; i++) begin
            m = 2'($urandom_range(0, 3));
            d = $urandom;
            case ($urandom_range(0, 3))
                0:       a = 8'($urandom_range(0, 255));
                1:       a = 8'($urandom_range(0, 8));
                2:       a = 8'($urandom_range(28, 36));
                default: a = 8'($urandom_range(60, 70));
            endcase
            applyStimulus(m, d, a, "random", -1);
            if (i % 3 == 0) idleCycle("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
